// File: rtl/bus_arb_pkg.sv
// Shared types for the split-transaction bus arbiter: FSM states, park-table
// entry layout and an index-width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    SPLIT = 2'd3
  } arb_state_t;

  // Wide enough for the largest supported master count (8)
  localparam int MST_IDX_W = 3;

  typedef logic [MST_IDX_W-1:0] mst_idx_t;

  typedef struct packed {
    logic     valid;
    mst_idx_t idx;
  } park_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational picker: returns the first set request bit, scanning upward
// from the pointer with wrap (round-robin) or from bit 0 (fixed priority).
module arb_rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  mst_idx_t     ptr,
  input  logic         rr_mode,
  output logic [N-1:0] pick,
  output logic         valid
);

  // Walk N positions starting at the base; the first requester found wins
  always_comb begin
    int   base;
    logic found;
    pick  = '0;
    found = 1'b0;
    base  = rr_mode ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < N; m++) begin
        if (!found && (m == ((base + k) % N)) && req[m]) begin
          pick[m] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/bus_arbiter_split.sv
// N-master bus arbiter with split-transaction parking, fixed or round-robin
// priority, and a grant-acceptance timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick a resumable parked master, else a fresh requester
// GRANT | grant issued, waiting for the owner to raise B_UTIL (timed)
// BUSY  | owner is driving the bus; watch for release or a split request
// SPLIT | one-cycle split notice to the owner, grant still shown
module bus_arbiter_split
  import bus_arb_pkg::*;
#(
  parameter int N_MST   = 2,
  parameter int N_SLV   = 3,
  parameter int RR_MODE = 1,
  parameter int GNT_TO  = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [N_MST-1:0] B_REQ,
  output logic [N_MST-1:0] B_GRANT,
  input  logic             B_UTIL,
  input  logic [N_SLV-1:0] B_SBSY,
  input  logic [N_SLV-1:0] B_SSPLIT,
  output logic             B_SPLIT,
  output logic             B_SPLIT_ERR
);

  localparam int            TW      = idx_w(GNT_TO);
  localparam logic [TW-1:0] TO_LOAD = TW'(GNT_TO - 1);
  localparam logic          RR_EN   = (RR_MODE != 0);

  arb_state_t       state_q, state_nxt;
  logic [N_MST-1:0] gnt_q, gnt_nxt;
  mst_idx_t         owner_q, owner_nxt;
  mst_idx_t         ptr_q, ptr_nxt, ptr_adv;
  logic [TW-1:0]    cnt_q, cnt_nxt;
  park_entry_t      park_q   [N_SLV];
  park_entry_t      park_nxt [N_SLV];
  logic             err_q, err_nxt;

  logic [N_MST-1:0] parked, elig, fresh_pick;
  logic             fresh_vld;
  logic [N_SLV-1:0] park_vld, park_req, resumable, res_pick, split_oh;
  logic             res_vld;
  logic             owner_req;

  // Decode park table and requests into eligibility / resumability vectors
  always_comb begin
    parked    = '0;
    park_vld  = '0;
    park_req  = '0;
    owner_req = 1'b0;
    for (int s = 0; s < N_SLV; s++) begin
      park_vld[s] = park_q[s].valid;
      for (int m = 0; m < N_MST; m++) begin
        if (park_q[s].idx == mst_idx_t'(m)) begin
          if (park_q[s].valid) parked[m] = 1'b1;
          park_req[s] = B_REQ[m];
        end
      end
    end
    for (int m = 0; m < N_MST; m++) begin
      if (owner_q == mst_idx_t'(m)) owner_req = B_REQ[m];
    end
    elig      = B_REQ & ~parked;
    resumable = park_vld & ~B_SBSY & park_req;
    // Only the lowest split request of a cycle is honoured
    split_oh  = B_SSPLIT & (~B_SSPLIT + N_SLV'(1));
    ptr_adv   = (owner_q == mst_idx_t'(N_MST - 1)) ? '0 : owner_q + mst_idx_t'(1);
  end

  arb_rr_picker #(.N(N_MST)) u_fresh_pick (
    .req     (elig),
    .ptr     (ptr_q),
    .rr_mode (RR_EN),
    .pick    (fresh_pick),
    .valid   (fresh_vld)
  );

  // Resume arbitration is by slave index, lowest first
  arb_rr_picker #(.N(N_SLV)) u_resume_pick (
    .req     (resumable),
    .ptr     ('0),
    .rr_mode (1'b0),
    .pick    (res_pick),
    .valid   (res_vld)
  );

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int s = 0; s < N_SLV; s++) park_q[s] <= '0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      owner_q <= owner_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
      for (int s = 0; s < N_SLV; s++) park_q[s] <= park_nxt[s];
    end
  end

  // Next-state, grant, timeout, pointer and park-table update
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
    park_nxt  = park_q;

    // A parked master that stops requesting gives up its slot
    for (int s = 0; s < N_SLV; s++) begin
      if (park_q[s].valid && !park_req[s]) park_nxt[s].valid = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (res_vld) begin
          for (int s = 0; s < N_SLV; s++) begin
            if (res_pick[s]) begin
              owner_nxt          = park_q[s].idx;
              park_nxt[s].valid  = 1'b0;
            end
          end
          state_nxt = GRANT;
          cnt_nxt   = TO_LOAD;
        end else if (fresh_vld) begin
          for (int m = 0; m < N_MST; m++) begin
            if (fresh_pick[m]) owner_nxt = mst_idx_t'(m);
          end
          state_nxt = GRANT;
          cnt_nxt   = TO_LOAD;
        end
        for (int m = 0; m < N_MST; m++) begin
          gnt_nxt[m] = (state_nxt == GRANT) && (owner_nxt == mst_idx_t'(m));
        end
      end

      GRANT: begin
        if (B_UTIL) begin
          state_nxt = BUSY;
        end else if (!owner_req || (cnt_q == '0)) begin
          // Withdrawn or timed out: pointer stays so the same master is favoured
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - TW'(1);
        end
      end

      BUSY: begin
        if (B_UTIL && (|split_oh)) begin
          for (int s = 0; s < N_SLV; s++) begin
            if (split_oh[s]) begin
              if (park_q[s].valid) begin
                err_nxt = 1'b1;
              end else begin
                park_nxt[s].valid = 1'b1;
                park_nxt[s].idx   = owner_q;
                state_nxt         = SPLIT;
                ptr_nxt           = ptr_adv;
              end
            end
          end
        end else if (!B_UTIL) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_adv;
        end
      end

      SPLIT: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: grant and error come from registers, split notice from state
  always_comb begin
    B_GRANT     = gnt_q;
    B_SPLIT     = (state_q == SPLIT);
    B_SPLIT_ERR = err_q;
  end

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Directed bench for bus_arbiter_split. Stimulus pushes the expected output
// events (grant/split/error vector plus cycles since the previous change)
// into a queue; a monitor pops one entry each time the DUT outputs change.
module tb_bus_arbiter_split;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [1:0] req, gnt, f_req, f_gnt;
  logic       util, f_util;
  logic [2:0] sbsy, sspl;
  logic       split, serr, f_split, f_serr;

  always #5 CLK = ~CLK;

  bus_arbiter_split #(.N_MST(2), .N_SLV(3), .RR_MODE(1), .GNT_TO(4)) dut_rr (
    .CLK(CLK), .RSTN(RSTN), .B_REQ(req), .B_GRANT(gnt), .B_UTIL(util),
    .B_SBSY(sbsy), .B_SSPLIT(sspl), .B_SPLIT(split), .B_SPLIT_ERR(serr)
  );

  bus_arbiter_split #(.N_MST(2), .N_SLV(3), .RR_MODE(0), .GNT_TO(4)) dut_fx (
    .CLK(CLK), .RSTN(RSTN), .B_REQ(f_req), .B_GRANT(f_gnt), .B_UTIL(f_util),
    .B_SBSY(3'b000), .B_SSPLIT(3'b000), .B_SPLIT(f_split), .B_SPLIT_ERR(f_serr)
  );

  typedef struct {
    logic [1:0] gnt;
    logic       split;
    logic       err;
    int         gap;   // 0 = first event of a test, gap not checked
  } evt_t;

  evt_t q_rr[$];
  evt_t q_fx[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void exp_ev(input bit sel, input logic [1:0] g, input logic s,
                                 input logic e, input int gap);
    evt_t x;
    x.gnt = g; x.split = s; x.err = e; x.gap = gap;
    if (sel) q_fx.push_back(x);
    else     q_rr.push_back(x);
  endfunction

  task automatic check_evt(input string nm, input evt_t got, input evt_t want);
    total++;
    if (got.gnt !== want.gnt || got.split !== want.split || got.err !== want.err ||
        (want.gap != 0 && got.gap != want.gap)) begin
      bad++;
      $display("FAIL %s: got gnt=%b split=%b err=%b gap=%0d, want gnt=%b split=%b err=%b gap=%0d",
               nm, got.gnt, got.split, got.err, got.gap,
               want.gnt, want.split, want.err, want.gap);
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic wait_gnt(input bit sel, input bit want_on, input string nm);
    int   n = 0;
    logic on;
    do begin
      @(negedge CLK);
      n++;
      on = sel ? (f_gnt != 2'b00) : (gnt != 2'b00);
    end while (on != want_on && n < 20);
    if (on != want_on) begin
      total++;
      bad++;
      $display("FAIL %s: grant active=%b after %0d cycles, want %b", nm, on, n, want_on);
    end
  endtask

  // Master behaviour: on seeing a grant, drive the bus for hold cycles
  task automatic own(input bit sel, input int hold, input logic [1:0] req_after);
    wait_gnt(sel, 1'b1, "own_wait");
    if (sel) f_util = 1'b1; else util = 1'b1;
    repeat (hold) @(negedge CLK);
    if (sel) begin f_util = 1'b0; f_req = req_after; end
    else     begin util   = 1'b0; req   = req_after; end
  endtask

  // Monitor: one scoreboard pop per output change of each instance
  initial begin : monitor
    logic [3:0] prev_r, prev_f, cur;
    int         cyc, last_r, last_f;
    evt_t       g, e;
    prev_r = '0; prev_f = '0; cyc = 0; last_r = 0; last_f = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      cur = {gnt, split, serr};
      if (cur !== prev_r) begin
        g.gnt = gnt; g.split = split; g.err = serr; g.gap = cyc - last_r;
        last_r = cyc; prev_r = cur;
        if (q_rr.size() == 0) begin
          total++; bad++;
          $display("FAIL rr_unexpected: got gnt=%b split=%b err=%b, want no change", gnt, split, serr);
        end else begin
          e = q_rr.pop_front();
          check_evt("rr_evt", g, e);
        end
      end
      cur = {f_gnt, f_split, f_serr};
      if (cur !== prev_f) begin
        g.gnt = f_gnt; g.split = f_split; g.err = f_serr; g.gap = cyc - last_f;
        last_f = cyc; prev_f = cur;
        if (q_fx.size() == 0) begin
          total++; bad++;
          $display("FAIL fx_unexpected: got gnt=%b split=%b err=%b, want no change", f_gnt, f_split, f_serr);
        end else begin
          e = q_fx.pop_front();
          check_evt("fx_evt", g, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RSTN = 1'b0; req = '0; util = 1'b0; sbsy = '0; sspl = '0;
    f_req = '0; f_util = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_split", {1'b0, split}, 2'b00);
    chk("rst_err", {1'b0, serr}, 2'b00);
    chk("rst_fx_gnt", f_gnt, 2'b00);
    chk("rst_fx_split", {1'b0, f_split}, 2'b00);
    chk("rst_fx_err", {1'b0, f_serr}, 2'b00);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // Round-robin alternation with one idle turnaround cycle
    exp_ev(0, 2'b01, 0, 0, 0); exp_ev(0, 2'b00, 0, 0, 4);
    exp_ev(0, 2'b10, 0, 0, 1); exp_ev(0, 2'b00, 0, 0, 4);
    exp_ev(0, 2'b01, 0, 0, 1); exp_ev(0, 2'b00, 0, 0, 4);
    req = 2'b11;
    own(0, 3, 2'b11);
    own(0, 3, 2'b11);
    own(0, 3, 2'b00);
    repeat (3) @(negedge CLK);

    // Fixed priority: master 0 wins every time
    exp_ev(1, 2'b01, 0, 0, 0); exp_ev(1, 2'b00, 0, 0, 4);
    exp_ev(1, 2'b01, 0, 0, 1); exp_ev(1, 2'b00, 0, 0, 4);
    f_req = 2'b11;
    own(1, 3, 2'b11);
    own(1, 3, 2'b00);
    repeat (3) @(negedge CLK);

    // Grant timeout to master 1; pointer unchanged so master 1 wins again
    exp_ev(0, 2'b10, 0, 0, 0); exp_ev(0, 2'b00, 0, 0, 4);
    exp_ev(0, 2'b10, 0, 0, 1); exp_ev(0, 2'b00, 0, 0, 4);
    req = 2'b11;
    wait_gnt(0, 1'b1, "to_grant");
    wait_gnt(0, 1'b0, "to_drop");
    own(0, 3, 2'b00);
    repeat (3) @(negedge CLK);

    // Split of master 0 on slave 0, then resume ahead of master 1
    exp_ev(0, 2'b01, 0, 0, 0); exp_ev(0, 2'b01, 1, 0, 2);
    exp_ev(0, 2'b00, 0, 0, 1); exp_ev(0, 2'b10, 0, 0, 1);
    exp_ev(0, 2'b00, 0, 0, 4); exp_ev(0, 2'b01, 0, 0, 1);
    exp_ev(0, 2'b00, 0, 0, 4);
    sbsy = 3'b001; req = 2'b11;
    wait_gnt(0, 1'b1, "sp_grant0");
    util = 1'b1;
    @(negedge CLK); sspl = 3'b001;
    @(negedge CLK); sspl = 3'b000; util = 1'b0;
    wait_gnt(0, 1'b1, "sp_grant1");
    util = 1'b1;
    @(negedge CLK); sbsy = 3'b000;
    @(negedge CLK);
    @(negedge CLK); util = 1'b0;
    own(0, 3, 2'b00);
    repeat (3) @(negedge CLK);

    // Split refused: slave 0 already holds parked master 0
    exp_ev(0, 2'b01, 0, 0, 0); exp_ev(0, 2'b01, 1, 0, 2);
    exp_ev(0, 2'b00, 0, 0, 1); exp_ev(0, 2'b10, 0, 0, 1);
    exp_ev(0, 2'b10, 0, 1, 2); exp_ev(0, 2'b10, 0, 0, 1);
    exp_ev(0, 2'b00, 0, 0, 2);
    sbsy = 3'b001; req = 2'b01;
    wait_gnt(0, 1'b1, "se_grant0");
    util = 1'b1;
    @(negedge CLK); sspl = 3'b001;
    @(negedge CLK); sspl = 3'b000; util = 1'b0; req = 2'b11;
    wait_gnt(0, 1'b1, "se_grant1");
    util = 1'b1;
    @(negedge CLK); sspl = 3'b001;
    @(negedge CLK); sspl = 3'b000;
    @(negedge CLK);
    @(negedge CLK); util = 1'b0; req = 2'b00; sbsy = 3'b000;
    repeat (3) @(negedge CLK);

    // Park master 1 (two split bits, lowest honoured), then reset in BUSY
    exp_ev(0, 2'b10, 0, 0, 0); exp_ev(0, 2'b10, 1, 0, 2);
    exp_ev(0, 2'b00, 0, 0, 1); exp_ev(0, 2'b01, 0, 0, 1);
    exp_ev(0, 2'b00, 0, 0, 3); exp_ev(0, 2'b10, 0, 0, 1);
    exp_ev(0, 2'b00, 0, 0, 4);
    sbsy = 3'b001; req = 2'b10;
    wait_gnt(0, 1'b1, "rs_grant1");
    util = 1'b1;
    @(negedge CLK); sspl = 3'b011;
    @(negedge CLK); sspl = 3'b000; util = 1'b0; req = 2'b11;
    wait_gnt(0, 1'b1, "rs_grant0");
    util = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b0; util = 1'b0; req = 2'b10;
    #1;
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_split", {1'b0, split}, 2'b00);
    chk("mid_rst_err", {1'b0, serr}, 2'b00);
    @(negedge CLK);
    RSTN = 1'b1;
    own(0, 3, 2'b00);
    sbsy = 3'b000;
    repeat (5) @(negedge CLK);

    chk("rr_queue_left", (q_rr.size() > 3) ? 2'b11 : 2'(q_rr.size()), 2'b00);
    chk("fx_queue_left", (q_fx.size() > 3) ? 2'b11 : 2'(q_fx.size()), 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
